// File: rtl/jk_drv_pkg.sv
// Shared constants for the JK excitation driver: FSM state encodings and
// the four excitation drive patterns, each packed as {J, K}.
package jk_drv_pkg;

  // FSM state enumeration
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // Excitation drive patterns {J, K}
  localparam logic [1:0] EXC_HOLD   = 2'b00;
  localparam logic [1:0] EXC_SET    = 2'b10;
  localparam logic [1:0] EXC_RST    = 2'b01;
  localparam logic [1:0] EXC_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_excitation.sv
// JK excitation table: given the present flip-flop state (cur) and the
// wanted next state (nxt), produce the J/K drive.
// Build option: define JK_DRV_TOGGLE_EN to resolve don't-cares as toggle
// (J=K=1) for state changes; otherwise the set/reset form is used.
module jk_excitation
  import jk_drv_pkg::*;
(
  input  logic cur,
  input  logic nxt,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  // Map the transition to a drive pattern; holds never drive.
  always_comb begin
    jk = EXC_HOLD;
    case ({cur, nxt})
`ifdef JK_DRV_TOGGLE_EN
      2'b01:   jk = EXC_TOGGLE;
      2'b10:   jk = EXC_TOGGLE;
`else
      2'b01:   jk = EXC_SET;
      2'b10:   jk = EXC_RST;
`endif
      default: jk = EXC_HOLD;
    endcase
  end

  assign j = jk[1];
  assign k = jk[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: accepts a target bit, drives an external JK
// flip-flop for one enable cycle, then verifies the fed-back Q.
// Build option: JK_DRV_TOGGLE_EN (selected inside jk_excitation).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a target; J/K/enable low
// DRIVE | enable high for one cycle with J/K from the latched transition
// CHECK | outputs low; compare fed-back Q against the latched target
// FAULT | sticky mismatch; wait for fault_clr
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic             J,
  output logic             K,
  output logic             enable,
  output logic             fault,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] good_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             tgt_lat;
  logic             q_lat;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;
  logic             exc_j;
  logic             exc_k;
  logic             transfer;
  logic             in_drive;
  logic             match;

  // Excitation decoded from the latched transition, so J/K depend only on
  // flops and stay stable for the whole DRIVE cycle.
  jk_excitation u_exc (
    .cur (q_lat),
    .nxt (tgt_lat),
    .j   (exc_j),
    .k   (exc_k)
  );

  // Reset forces IDLE asynchronously, so ready must also be masked by the
  // reset level itself to stay low while reset is held.
  assign tgt_ready = (state == ST_IDLE) && !reset_async;
  assign transfer  = tgt_valid && tgt_ready;
  assign in_drive  = (state == ST_DRIVE);
  assign match     = (q_fb == tgt_lat);

  assign enable   = in_drive;
  assign J        = in_drive & exc_j;
  assign K        = in_drive & exc_k;
  assign fault    = fault_q;
  assign good_cnt = cnt_q;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (transfer) state_nxt = ST_DRIVE;
      ST_DRIVE: state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = match ? ST_IDLE : ST_FAULT;
      ST_FAULT: if (fault_clr) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Capture target and present Q at the moment of transfer.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      tgt_lat <= 1'b0;
      q_lat   <= 1'b0;
    end else if (transfer) begin
      tgt_lat <= tgt_bit;
      q_lat   <= q_fb;
    end
  end

  // Sticky fault: set on a CHECK mismatch, cleared only from FAULT.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async)                            fault_q <= 1'b0;
    else if (state == ST_CHECK && !match)       fault_q <= 1'b1;
    else if (state == ST_FAULT && fault_clr)    fault_q <= 1'b0;
  end

  // Saturating count of verified updates.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async)
      cnt_q <= '0;
    else if (state == ST_CHECK && match && cnt_q != CNT_MAX)
      cnt_q <= cnt_q + CNT_ONE;
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver paired with a behavioural JK flip-flop.
// Stimulus pushes expected results into a scoreboard; a monitor pops one
// entry per enable pulse and checks DRIVE, CHECK and post-CHECK outputs.
module tb_jk_excitation_driver;

  typedef struct {
    logic j;
    logic k;
    logic q;
    int   cnt;
    logic flt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_async = 1'b1;
  logic       tgt_valid = 1'b0;
  logic       tgt_bit = 1'b0;
  logic       fault_clr = 1'b0;
  logic       ff_block = 1'b0;
  logic       q;
  logic       tgt_ready, J, K, enable, fault;
  logic [7:0] good_cnt;
  logic       tgt_ready2, J2, K2, enable2, fault2;
  logic [1:0] good_cnt2;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_xfer = 0;
  logic m_q = 1'b0;
  int   m_cnt = 0;
  exp_t sb[$];

  jk_excitation_driver #(.CNT_W(8)) u_dut (
    .clk(clk), .reset_async(reset_async), .tgt_valid(tgt_valid),
    .tgt_bit(tgt_bit), .tgt_ready(tgt_ready), .q_fb(q), .J(J), .K(K),
    .enable(enable), .fault(fault), .fault_clr(fault_clr),
    .good_cnt(good_cnt)
  );

  jk_excitation_driver #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_async(reset_async), .tgt_valid(tgt_valid),
    .tgt_bit(tgt_bit), .tgt_ready(tgt_ready2), .q_fb(q), .J(J2), .K(K2),
    .enable(enable2), .fault(fault2), .fault_clr(fault_clr),
    .good_cnt(good_cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural JK flip-flop; ff_block models a stuck-low enable.
  always @(posedge clk or posedge reset_async) begin
    if (reset_async) q <= 1'b0;
    else if (enable && !ff_block) begin
      case ({J, K})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Hand-written excitation table for the expected drive.
  function automatic logic [1:0] exp_jk(input logic cur, input logic nxt);
`ifdef JK_DRV_TOGGLE_EN
    case ({cur, nxt})
      2'b01, 2'b10: return 2'b11;
      default:      return 2'b00;
    endcase
`else
    case ({cur, nxt})
      2'b01:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
`endif
  endfunction

  task automatic send(input logic t);
    int   w;
    exp_t e;
    logic [1:0] jk;
    w = 0;
    @(negedge clk);
    while (!tgt_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!tgt_ready) begin
      chk("ready_timeout", 32'(tgt_ready), 32'd1);
      return;
    end
    jk    = exp_jk(m_q, t);
    e.j   = jk[1];
    e.k   = jk[0];
    e.q   = ff_block ? m_q : t;
    e.flt = (e.q != t);
    if (!e.flt && m_cnt < 255) m_cnt++;
    e.cnt = m_cnt;
    m_q   = e.q;
    sb.push_back(e);
    tgt_valid = 1'b1;
    tgt_bit   = t;
    @(posedge clk);
    #1;
    last_xfer = cyc;
    tgt_valid = 1'b0;
  endtask

  // Monitor: one scoreboard entry per enable pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (enable === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_drive", 32'(enable), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("drive_jk", 32'({J, K}), 32'({e.j, e.k}));
          chk("drive_jk_w2", 32'({J2, K2, enable2}), 32'({e.j, e.k, 1'b1}));
          @(negedge clk);
          chk("check_outs", 32'({enable, J, K}), 32'd0);
          chk("check_q", 32'(q), 32'(e.q));
          @(negedge clk);
          chk("good_cnt", 32'(good_cnt), e.cnt);
          chk("good_cnt_sat", 32'(good_cnt2), (e.cnt > 3) ? 3 : e.cnt);
          chk("fault", 32'(fault), 32'(e.flt));
          chk("fault_w2", 32'(fault2), 32'(e.flt));
          chk("ready_after", 32'({tgt_ready, tgt_ready2}), e.flt ? 32'd0 : 32'd3);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    // Reset held 100 ns, released on a falling edge.
    #95;
    chk("ready_in_reset", 32'(tgt_ready), 32'd0);
    chk("outs_in_reset", 32'({J, K, enable, fault}), 32'd0);
    #5;
    reset_async = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rel", 32'({tgt_ready, tgt_ready2}), 32'd3);
    chk("q_after_rel", 32'(q), 32'd0);
    chk("outs_after_rel", 32'({J, K, enable, fault}), 32'd0);
    chk("cnt_after_rel", 32'(good_cnt), 32'd0);

    // Back-to-back targets 1,1,0,0,1.
    send(1'b1);
    first = last_xfer;
    send(1'b1);
    send(1'b0);
    send(1'b0);
    send(1'b1);
    chk("throughput", 32'(last_xfer - first), 32'd12);
    repeat (3) @(negedge clk);
    chk("seq_cnt", 32'(good_cnt), 32'd5);
    chk("seq_sat", 32'(good_cnt2), 32'd3);
    chk("seq_q", 32'(q), 32'd1);

    // fault_clr outside FAULT has no effect.
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_idle", 32'({fault, tgt_ready}), 32'b01);
    chk("clr_idle_cnt", 32'(good_cnt), 32'd5);

    // Bring Q to 0, then block the flip-flop and ask for 1.
    send(1'b0);
    repeat (3) @(negedge clk);
    ff_block = 1'b1;
    send(1'b1);
    repeat (3) @(negedge clk);
    tgt_valid = 1'b1;
    tgt_bit   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("fault_hold", 32'({fault, tgt_ready, enable}), 32'b100);
    end
    chk("fault_cnt", 32'(good_cnt), 32'd6);
    tgt_valid = 1'b0;
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
    ff_block  = 1'b0;
    chk("fault_cleared", 32'({fault, tgt_ready}), 32'b01);
    repeat (4) @(negedge clk);
    chk("no_queued_offer", 32'(q), 32'd0);

    // Reset pulse in the middle of DRIVE.
    send(1'b1);
    #1;
    chk("enable_in_drive", 32'(enable), 32'd1);
    #1;
    reset_async = 1'b1;
    #1;
    chk("rst_drop_enable", 32'({enable, J, K}), 32'd0);
    chk("rst_ready_low", 32'(tgt_ready), 32'd0);
    chk("rst_state", 32'({fault, good_cnt}), 32'd0);
    void'(sb.pop_back());
    m_q   = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    reset_async = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_reissue", 32'({enable, tgt_ready, q}), 32'b010);
    end

    // Resume normal operation after reset.
    send(1'b1);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_excitation_driver.md
JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

Interface
REQ-001 Parameter CNT_W, default 8, width of the good-update counter.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_async  input  1  asynchronous, active-high reset.
REQ-004 tgt_valid  input  1  target bit offered.
REQ-005 tgt_bit  input  1  desired next flip-flop state.
REQ-006 tgt_ready  output  1  block can accept a target.
REQ-007 q_fb  input  1  Q fed back from the driven JK flip-flop.
REQ-008 J  output  1  J drive to the flip-flop.
REQ-009 K  output  1  K drive to the flip-flop.
REQ-010 enable  output  1  flip-flop enable strobe.
REQ-011 fault  output  1  sticky mismatch flag.
REQ-012 fault_clr  input  1  clears fault.
REQ-013 good_cnt  output  CNT_W  count of verified updates.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, CHECK and FAULT, with IDLE after reset.
REQ-015 tgt_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with tgt_valid=1 and tgt_ready=1.
REQ-016 On a transfer the block SHALL latch tgt_bit and q_fb, register J/K from the excitation table, and go to DRIVE.
REQ-017 Excitation (current->target): 0->0 J=0,K=x; 0->1 J=1,K=x; 1->0 J=x,K=1; 1->1 J=x,K=0.
REQ-018 In DRIVE, enable SHALL be 1 for exactly one cycle with registered J/K; the next state SHALL be CHECK.
REQ-019 In CHECK, enable, J and K SHALL be 0; q_fb SHALL be compared with the latched target.
REQ-020 On a CHECK match, good_cnt SHALL increment, saturating at 2^CNT_W-1, and the next state SHALL be IDLE.
REQ-021 On a CHECK mismatch, the next state SHALL be FAULT, fault SHALL be 1, and good_cnt SHALL be unchanged.
REQ-022 In FAULT, tgt_ready SHALL be 0 and fault SHALL hold 1 until fault_clr=1 is sampled; the next state is then IDLE and fault is 0.
REQ-023 fault_clr SHALL be ignored outside FAULT.
REQ-024 tgt_valid while tgt_ready=0 SHALL have no effect, and the offer SHALL NOT be queued.
REQ-025 Throughput SHALL be one target per 3 cycles (IDLE, DRIVE, CHECK); tgt_ready SHALL be 1 in the cycle after a matching CHECK.
REQ-026 Outside DRIVE, enable SHALL be 0.

Reset
REQ-027 reset_async=1 SHALL immediately force: state IDLE; J, K, enable and fault to 0; good_cnt to 0; latched target and latched Q to 0.
REQ-028 Reset asserted during DRIVE SHALL drop enable in the same time step without waiting for a clock edge.
REQ-029 tgt_ready SHALL be 0 while reset_async=1 and SHALL be 1 on the first cycle after release.

Configuration
REQ-030 The macro JK_DRV_TOGGLE_EN SHALL select how don't-care (x) entries are resolved.
REQ-031 With JK_DRV_TOGGLE_EN defined, x SHALL resolve to 1 for state changes (0->1 and 1->0 drive J=1,K=1) and to 0 for holds.
REQ-032 Without JK_DRV_TOGGLE_EN, every x SHALL resolve to 0 (set/reset form).

Structure
REQ-033 The package jk_drv_pkg SHALL hold the state enumeration and the four excitation J/K constants.
REQ-034 The excitation table SHALL be a combinational sub-module, jk_excitation (inputs cur, nxt; outputs j, k), that contains the macro selection.
REQ-035 The top level SHALL contain the FSM, the input latches, the output registers and the counter.

Verification (bench pairs the block with the team JK flip-flop model; q_fb=Q)
REQ-036 Reset and release: reset_async=1 for 100 ns, then 0 -> Q=0, J=K=enable=0, good_cnt=0, tgt_ready=1 on the first edge after release.
REQ-037 Target sequence 1,1,0,0,1 -> Q follows each target one edge after the DRIVE cycle, good_cnt=5, fault=0, 15 cycles total.
REQ-038 JK_DRV_TOGGLE_EN defined, target 1 from Q=0 -> J=1,K=1 in DRIVE; undefined -> J=1,K=0; Q=1 in both builds.
REQ-039 Flip-flop enable forced low, target 1 -> CHECK mismatch, fault=1, tgt_ready=0 held for 20 cycles; fault_clr pulse -> IDLE, fault=0.
REQ-040 CNT_W=2, 5 matching targets -> good_cnt saturates at 3.
REQ-041 reset_async pulsed during DRIVE -> enable drops without a clock edge, state IDLE, and the held target is not re-issued.
